restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/divider_pkg.sv | 12 +
 rtl/div_step.sv | 23 ++
 rtl/restoring_divider.sv | 117 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and defaults for the restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] div_i,
  output logic [N-1:0] rem_o,
  output logic [N-1:0] quo_o
);

  logic [N:0] shifted;
  logic [N:0] diff;

  // rem_i < div_i always holds, so the shifted value fits N+1 bits and diff[N] is the borrow.
  assign shifted = {rem_i, quo_i[N-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign rem_o   = diff[N] ? shifted[N-1:0] : diff[N-1:0];
  assign quo_o   = {quo_i[N-2:0], ~diff[N]};

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: N-cycle shift/subtract loop with a zero-divisor fast path.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module restoring_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  prem_q, quo_q, dvs_q;
  logic [N-1:0]  prem_d, quo_d;
  logic [N-1:0]  quotient_q, remainder_q;
  logic          done_q, dbz_q;
  logic [N-1:0]  a_mag, b_mag, q_fin, r_fin;

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, rneg_q;

  // Most-negative magnitude is exact as an unsigned N-bit value, so wrap cases fall out naturally.
  assign a_mag = dividend[N-1] ? -dividend : dividend;
  assign b_mag = divisor[N-1]  ? -divisor  : divisor;
  assign q_fin = qneg_q ? -quo_d  : quo_d;
  assign r_fin = rneg_q ? -prem_d : prem_d;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = quo_d;
  assign r_fin = prem_d;
`endif

  div_step #(.N(N)) u_step (
    .rem_i (prem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (prem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= CALC;
              dbz_q   <= 1'b0;
              cnt_q   <= '0;
              prem_q  <= '0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
`ifdef DIVIDER_SIGNED_EN
              qneg_q  <= dividend[N-1] ^ divisor[N-1];
              rneg_q  <= dividend[N-1];
`endif
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            quotient_q  <= q_fin;
            remainder_q <= r_fin;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
